// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter (IF/MEM sharing of one bus).
// The optional bus timeout is enabled with MEM_ARB_TIMEOUT_EN.
package mem_port_arbiter_pkg;

  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_TIMEOUT_CYC = 255;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    GNT_FETCH = 1'b0,
    GNT_DATA  = 1'b1
  } grant_e;

endpackage

// File: rtl/mem_port_arbiter_timeout_cnt.sv
// Bus-wait watchdog: clears on grant, counts un-acked bus cycles, flags the last allowed one.
// Only built when MEM_ARB_TIMEOUT_EN is defined.
`ifdef MEM_ARB_TIMEOUT_EN
module arb_timeout_cnt
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Fires on the TIMEOUT_CYC-th waiting cycle so the bus is held exactly that long.
  assign expire_o = en_i && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Shares the single external memory port between instruction fetch and data access.
// Define MEM_ARB_TIMEOUT_EN to abort bus transactions that never see bus_ack.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              pipe_hold,
  output logic              timeout_err
);

  arb_state_e        state_q, state_d;
  grant_e            last_grant_q, last_grant_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              grant_data;

  // On a tie the data side wins unless it was served last.
  assign grant_data = mem_req && (!if_req || (last_grant_q == GNT_FETCH));

`ifdef MEM_ARB_TIMEOUT_EN
  logic timeout_err_q, timeout_err_d;
  logic tmo_grant, tmo_busy, tmo_expire;

  assign tmo_grant = (state_q == IDLE) && (if_req || mem_req);
  assign tmo_busy  = (state_q == FETCH) || (state_q == DATA);

  arb_timeout_cnt #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout_cnt (
    .clk     (clk),
    .rst     (reset),
    .clr_i   (tmo_grant),
    .en_i    (tmo_busy && !bus_ack),
    .expire_o(tmo_expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timeout_err_q <= 1'b0;
    end else begin
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  // The limit only has meaning when the watchdog is built in.
  if (TIMEOUT_CYC < 1) begin : g_timeout_cyc_unused
  end

  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    if_rdata_d   = if_rdata_q;
    mem_rdata_d  = mem_rdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
    timeout_err_d = timeout_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (if_req || mem_req) begin
          state_d      = grant_data ? DATA : FETCH;
          last_grant_d = grant_data ? GNT_DATA : GNT_FETCH;
          bus_req_d    = 1'b1;
          bus_we_d     = grant_data ? mem_we : 1'b0;
          bus_addr_d   = grant_data ? mem_addr : if_addr;
          bus_wdata_d  = grant_data ? mem_wdata : DATA_W'(NOP_WORD);
        end
      end
      FETCH, DATA: begin
        if (bus_ack) begin
          state_d   = RESP;
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
          if (state_q == FETCH) begin
            if_rdata_d = bus_rdata;
          end else if (!bus_we_q) begin
            mem_rdata_d = bus_rdata;
          end
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (tmo_expire) begin
          state_d       = RESP;
          bus_req_d     = 1'b0;
          bus_we_d      = 1'b0;
          timeout_err_d = 1'b1;
          if (state_q == FETCH) begin
            if_rdata_d = DATA_W'(NOP_WORD);
          end else if (!bus_we_q) begin
            mem_rdata_d = DATA_W'(NOP_WORD);
          end
        end
`endif
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_FETCH;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      if_rdata_q   <= '0;
      mem_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      if_rdata_q   <= if_rdata_d;
      mem_rdata_q  <= mem_rdata_d;
    end
  end

  // RESP lasts one cycle, so decoding it gives the single-cycle ready pulse.
  assign if_ready  = (state_q == RESP) && (last_grant_q == GNT_FETCH);
  assign mem_ready = (state_q == RESP) && (last_grant_q == GNT_DATA);
  assign pipe_hold = (if_req && !if_ready) || (mem_req && !mem_ready);

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// against a transaction-level timing model; the watchdog test runs when MEM_ARB_TIMEOUT_EN is set.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              if_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;
  logic              mem_req = 1'b0;
  logic              mem_we = 1'b0;
  logic [ADDR_W-1:0] mem_addr = '0;
  logic [DATA_W-1:0] mem_wdata = '0;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_ack = 1'b0;
  logic [DATA_W-1:0] bus_rdata = '0;
  logic              pipe_hold;
  logic              timeout_err;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .pipe_hold(pipe_hold), .timeout_err(timeout_err)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transaction-level model: one grant occupies the port from its grant cycle until
  // the cycle after the ready pulse; timing follows grant -> bus -> ack -> ready.
  int          cyc = 0;
  int          g_c = -100, ack_c = -100, rdy_c = -100, free_at = 0;
  bit          who_data = 1'b0, last_data = 1'b0;
  bit          tr_we = 1'b0;
  logic [31:0] tr_addr = '0, tr_wdata = '0, tr_rd = '0;
  logic [31:0] exp_if_rd = '0, exp_mem_rd = '0;
  bit          exp_terr = 1'b0;

  bit          if_pend = 1'b0, mem_pend = 1'b0, mem_w = 1'b0;
  logic [31:0] if_a = '0, mem_a = '0, mem_d = '0;

  bit          auto_req = 1'b0, spur_en = 1'b0, spur_force = 1'b0, fix_rd_en = 1'b0;
  int          fix_l = -1;
  logic [31:0] fix_rd = '0;
  bit          rdy_log[$];
  int          busreq_cnt = 0;

  task automatic step();
    logic [31:0] rd;
    bit          e_ifr, e_memr, in_win;
    int          l;
    @(posedge clk);
    cyc++;
    #1;
    if (cyc == rdy_c) begin
      if (!who_data) exp_if_rd = tr_rd;
      else if (!tr_we) exp_mem_rd = tr_rd;
    end
    in_win = (cyc > g_c) && (cyc <= ack_c);
    e_ifr  = (cyc == rdy_c) && !who_data;
    e_memr = (cyc == rdy_c) && who_data;
    check("bus_req", bus_req, in_win);
    if (in_win) begin
      busreq_cnt++;
      check("bus_we", bus_we, tr_we);
      check("bus_addr", bus_addr, tr_addr);
      if (tr_we) check("bus_wdata", bus_wdata, tr_wdata);
    end
    check("if_ready", if_ready, e_ifr);
    check("mem_ready", mem_ready, e_memr);
    if (if_ready) rdy_log.push_back(1'b0);
    if (mem_ready) rdy_log.push_back(1'b1);
    check("if_rdata", if_rdata, exp_if_rd);
    check("mem_rdata", mem_rdata, exp_mem_rd);
    check("timeout_err", timeout_err, exp_terr);

    // Requesters drop the request the cycle after their ready pulse.
    if (cyc == rdy_c + 1) begin
      if (who_data) mem_pend = 1'b0;
      else if_pend = 1'b0;
    end
    if (auto_req && in_win && $urandom_range(15) == 0) begin
      if (who_data) mem_pend = 1'b0;
      else if_pend = 1'b0;
    end
    if (auto_req) begin
      if (!if_pend && $urandom_range(2) == 0) begin
        if_pend = 1'b1;
        if_a    = $urandom;
      end
      if (!mem_pend && $urandom_range(2) == 0) begin
        mem_pend = 1'b1;
        mem_w    = 1'($urandom_range(1));
        mem_a    = $urandom;
        mem_d    = $urandom;
      end
    end
    if_req    = if_pend;
    if_addr   = if_a;
    mem_req   = mem_pend;
    mem_we    = mem_w;
    mem_addr  = mem_a;
    mem_wdata = mem_d;

    rd = fix_rd_en ? fix_rd : $urandom;
    bus_rdata = rd;
    if (cyc == ack_c) begin
      bus_ack = 1'b1;
      tr_rd   = rd;
    end else if (cyc > g_c && cyc < ack_c) begin
      bus_ack = 1'b0;
    end else begin
      bus_ack = spur_force || (spur_en && $urandom_range(3) == 0);
    end

    if (cyc >= free_at && (if_pend || mem_pend)) begin
      who_data  = mem_pend && (!if_pend || !last_data);
      last_data = who_data;
      l         = (fix_l >= 0) ? fix_l : int'($urandom_range(2));
      g_c       = cyc;
      ack_c     = cyc + 1 + l;
      rdy_c     = cyc + 2 + l;
      free_at   = cyc + 3 + l;
      tr_we     = who_data ? mem_w : 1'b0;
      tr_addr   = who_data ? mem_a : if_a;
      tr_wdata  = mem_d;
    end
    #1;
    check("pipe_hold", pipe_hold, (if_req && !e_ifr) || (mem_req && !e_memr));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b1;
    if_req  = 1'b0;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    bus_ack = 1'b0;
    if_pend = 1'b0;
    mem_pend = 1'b0;
    #1;
    check("rst_bus_req", bus_req, 1'b0);
    check("rst_bus_we", bus_we, 1'b0);
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_bus_wdata", bus_wdata, 32'h0);
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_mem_rdata", mem_rdata, 32'h0);
    check("rst_if_ready", if_ready, 1'b0);
    check("rst_mem_ready", mem_ready, 1'b0);
    check("rst_pipe_hold", pipe_hold, 1'b0);
    check("rst_timeout_err", timeout_err, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset      = 1'b0;
    g_c        = -100;
    ack_c      = -100;
    rdy_c      = -100;
    free_at    = 0;
    last_data  = 1'b0;
    exp_if_rd  = '0;
    exp_mem_rd = '0;
    exp_terr   = 1'b0;
  endtask

  initial begin
    do_reset();

    // Lone fetch with two wait cycles.
    if_pend = 1'b1; if_a = 32'h0040_0000;
    fix_l = 2; fix_rd_en = 1'b1; fix_rd = 32'h2008_0005;
    busreq_cnt = 0; rdy_log.delete();
    repeat (6) step();
    check("fetch_bus_cycles", busreq_cnt, 3);
    check("fetch_pulses", rdy_log.size(), 1);
    check("fetch_rdata", if_rdata, 32'h2008_0005);

    // Two tie rounds after reset: DATA, FETCH, DATA, FETCH.
    do_reset();
    fix_l = -1; fix_rd_en = 1'b0; rdy_log.delete();
    for (int r = 0; r < 2; r++) begin
      if_pend = 1'b1; if_a = 32'h0000_1000 + r;
      mem_pend = 1'b1; mem_w = 1'b0; mem_a = 32'h2000_0000 + r;
      repeat (12) step();
    end
    check("tie_count", rdy_log.size(), 4);
    if (rdy_log.size() == 4) begin
      check("tie_0_data", rdy_log[0], 1'b1);
      check("tie_1_fetch", rdy_log[1], 1'b0);
      check("tie_2_data", rdy_log[2], 1'b1);
      check("tie_3_fetch", rdy_log[3], 1'b0);
    end

    // Load, then a store that must leave mem_rdata alone.
    mem_pend = 1'b1; mem_w = 1'b0; mem_a = 32'h1000_0000;
    fix_l = 0; fix_rd_en = 1'b1; fix_rd = 32'h1234_5678;
    repeat (5) step();
    check("load_rdata", mem_rdata, 32'h1234_5678);
    mem_pend = 1'b1; mem_w = 1'b1; mem_a = 32'h1000_0004; mem_d = 32'hDEAD_BEEF;
    fix_rd = 32'hFFFF_0000; rdy_log.delete();
    step();
    step();
    check("store_bus_we", bus_we, 1'b1);
    check("store_bus_addr", bus_addr, 32'h1000_0004);
    check("store_bus_wdata", bus_wdata, 32'hDEAD_BEEF);
    repeat (4) step();
    check("store_keeps_rdata", mem_rdata, 32'h1234_5678);
    check("store_pulses", rdy_log.size(), 1);

    // Spurious acks in IDLE and RESP.
    spur_force = 1'b1; rdy_log.delete();
    repeat (3) step();
    if_pend = 1'b1; if_a = 32'h0040_0010; fix_l = 1; fix_rd = 32'h0BAD_F00D;
    repeat (6) step();
    spur_force = 1'b0;
    check("spur_pulses", rdy_log.size(), 1);
    check("spur_rdata", if_rdata, 32'h0BAD_F00D);

    // Reset in the middle of a data access.
    mem_pend = 1'b1; mem_w = 1'b0; mem_a = 32'h3000_0000; fix_l = 2;
    step();
    step();
    check("pre_rst_bus_req", bus_req, 1'b1);
    do_reset();
    repeat (3) step();

    // Randomized traffic.
    auto_req = 1'b1; spur_en = 1'b1; fix_l = -1; fix_rd_en = 1'b0;
    repeat (3000) step();
    auto_req = 1'b0; spur_en = 1'b0;
    repeat (12) step();

`ifdef MEM_ARB_TIMEOUT_EN
    do_reset();
    if_pend = 1'b1; if_a = 32'h0040_0020; fix_l = 0; fix_rd_en = 1'b1; fix_rd = 32'hAAAA_5555;
    repeat (5) step();
    check("pre_tmo_rdata", if_rdata, 32'hAAAA_5555);
    begin
      int  n;
      bit  seen;
      n = 0;
      seen = 1'b0;
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h0040_0024; bus_ack = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(posedge clk);
        #1;
        if (bus_req) n++;
        if (if_ready) begin
          seen = 1'b1;
          check("tmo_rdata", if_rdata, 32'h0);
          check("tmo_err_set", timeout_err, 1'b1);
          if_req = 1'b0;
        end
      end
      check("tmo_seen", seen, 1'b1);
      check("tmo_bus_cycles", n, TMO);
      @(negedge clk);
      if_req = 1'b0; bus_ack = 1'b1;
      @(negedge clk);
      bus_ack = 1'b0;
      repeat (3) @(negedge clk);
      check("tmo_late_bus_req", bus_req, 1'b0);
      check("tmo_late_ready", {if_ready, mem_ready}, 2'b00);
      check("tmo_err_sticky", timeout_err, 1'b1);
    end
    do_reset();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the CPU's single external memory port between instruction fetch (IF stage) and data access (MEM stage).
- Sequences one bus transaction at a time through a request/ack handshake.
- Returns data to the winning requester.
- Generates the pipeline hold signal that freezes all stages while any access is outstanding. It sits between the pipeline and the memory bus, alongside the hazard unit.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT_CYC, 255, cycles without bus_ack before abort (optional feature only)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
if_req  in  1  IF stage requests instruction fetch
if_addr  in  ADDR_W  fetch address (PC)
if_rdata  out  DATA_W  fetched instruction, registered
if_ready  out  1  one-cycle pulse: if_rdata valid, fetch complete
mem_req  in  1  MEM stage requests data access
mem_we  in  1  1 = store, 0 = load
mem_addr  in  ADDR_W  data address
mem_wdata  in  DATA_W  store data
mem_rdata  out  DATA_W  load data, registered
mem_ready  out  1  one-cycle pulse: data access complete
bus_req  out  1  external bus request, registered
bus_we  out  1  external write enable, registered
bus_addr  out  ADDR_W  external address, registered
bus_wdata  out  DATA_W  external write data, registered
bus_ack  in  1  one-cycle completion from memory; bus_rdata valid in the same cycle
bus_rdata  in  DATA_W  external read data
pipe_hold  out  1  combinational: (if_req & ~if_ready) | (mem_req & ~mem_ready)
timeout_err  out  1  sticky abort flag (optional feature)

Behaviour:
- States: IDLE, FETCH, DATA, RESP.
- Reset values: state IDLE; all bus_* 0; if_rdata/mem_rdata 0; if_ready/mem_ready 0; last_grant = FETCH; timeout_err 0.
- IDLE: on request, latch address/we/wdata into bus_* and set bus_req = 1 at the next edge.
  - mem_req only → DATA.
  - if_req only → FETCH.
  - Both pending: grant the requester not equal to last_grant. Since last_grant resets to FETCH, the first tie goes to DATA.
  - Update last_grant on every grant.
- FETCH/DATA: hold bus_req and all bus_* stable until bus_ack.
  - On the ack edge: bus_req → 0; capture bus_rdata into if_rdata (FETCH) or mem_rdata (DATA load only; stores leave mem_rdata unchanged); go to RESP.
- RESP: pulse exactly one of if_ready/mem_ready for one cycle; no new grant; return to IDLE.
  - The requester keeps req high during the ready cycle, so RESP prevents a double grant.
- Latency: req seen in IDLE cycle t → bus_req at t+1 → ack at t+1+L (L ≥ 0 extra wait cycles) → ready at t+2+L. Minimum 3 cycles, ack in first bus_req cycle.
- bus_ack outside FETCH/DATA: ignored.
- A request dropped while in FETCH/DATA does not abort the bus transaction; it completes and the ready pulse is still issued.
- Reset mid-transaction: bus_req deasserts immediately (async); the memory side must tolerate an abandoned request.
- Address/data arithmetic: none; fields pass through width-exact.

Optional Feature:
MEM_ARB_TIMEOUT_EN
- Defined: a counter clears on grant and increments each FETCH/DATA cycle without ack.
  - On reaching TIMEOUT_CYC: drop bus_req, load rdata with 0 (NOP for fetch), go to RESP, set timeout_err (sticky until reset).
  - A late ack after abort is ignored.
- Undefined: no counter; waits indefinitely; timeout_err tied to 0.

Decomposition:
- Shared package: state encoding (IDLE = 2'd0, FETCH = 2'd1, DATA = 2'd2, RESP = 2'd3), grant IDs (GNT_FETCH, GNT_DATA), NOP constant 32'h0000_0000, default widths.
- One natural sub-module, arb_timeout_cnt: clear/enable/expire counter, instantiated only under MEM_ARB_TIMEOUT_EN.

Test Plan:
- Lone fetch: if_req = 1, if_addr = 0x0040_0000, ack after 2 wait cycles with rdata 0x2008_0005 → bus_req for 3 cycles, if_ready pulses once with if_rdata = 0x2008_0005; pipe_hold high until that cycle.
- Simultaneous if_req/mem_req after reset → DATA granted first; FETCH granted after RESP; two alternating ties grant DATA, FETCH, DATA, FETCH.
- Store: mem_we = 1, mem_addr = 0x1000_0004, mem_wdata = 0xDEAD_BEEF → bus_we = 1 with those values; mem_ready pulses; mem_rdata keeps its prior value.
- Spurious bus_ack in IDLE and RESP → no state change, no ready pulse.
- Reset asserted mid-DATA → bus_req = 0 in the same cycle; after release state is IDLE and all outputs are 0.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYC = 4, no ack → abort after 4 cycles; if_ready pulses with if_rdata = 0; timeout_err stays 1 until reset.
